// File: rtl/weight_buffer_responder.sv
// Conv weight buffer: 64-bit sequential load, LANES independent byte reads.
// Define WBUF_RD_PIPE_EN for a second output register stage (2-cycle reads).
module weight_buffer_responder #(
  parameter int LANES       = 16,
  parameter int ADDR_W      = 17,
  parameter int DEPTH_BYTES = 9408,
  parameter int WR_W        = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_loadStart,
  input  logic                    io_wrEn,
  input  logic [WR_W-1:0]         io_wrData,
  output logic                    io_ready,
  output logic [10:0]             io_loadCount,
  input  logic [LANES*ADDR_W-1:0] io_rdAddr,
  input  logic [LANES-1:0]        io_addrValid,
  output logic [LANES*8-1:0]      io_rdData,
  output logic [LANES-1:0]        io_rdValid,
  output logic                    io_addrErr
);

  localparam int BPW   = WR_W / 8;
  localparam int WORDS = DEPTH_BYTES / BPW;
  localparam int IDX_W = $clog2(DEPTH_BYTES);
  localparam int PTR_W = 11;

  typedef enum logic [1:0] {
    EMPTY,
    LOAD,
    READY
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [7:0]         mem [DEPTH_BYTES];
  logic               do_wr;
  logic               oor;
  logic [LANES-1:0]   rd_v;
  logic [LANES*8-1:0] rd_d;

  assign do_wr = (state == LOAD) && io_wrEn
              && !io_loadStart && !reset;
  assign io_loadCount = ptr;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= EMPTY;
      ptr        <= '0;
      io_ready   <= 1'b0;
      io_addrErr <= 1'b0;
    end else if (io_loadStart) begin
      state      <= LOAD;
      ptr        <= '0;
      io_ready   <= 1'b0;
      io_addrErr <= 1'b0;
    end else begin
      if (oor)
        io_addrErr <= 1'b1;
      if (do_wr) begin
        ptr <= ptr + 1'b1;
        if (ptr == PTR_W'(WORDS - 1)) begin
          state    <= READY;
          io_ready <= 1'b1;
        end
      end
    end
  end

  // Contents survive reset; only the load FSM restarts.
  always_ff @(posedge clock) begin
    if (do_wr) begin
      for (int k = 0; k < BPW; k++)
        mem[IDX_W'(int'(ptr) * BPW + k)] <= io_wrData[8*k +: 8];
    end
  end

  always_comb begin
    rd_v = '0;
    rd_d = '0;
    oor  = 1'b0;
    if (state == READY) begin
      for (int i = 0; i < LANES; i++) begin
        if (io_addrValid[i]) begin
          if (io_rdAddr[i*ADDR_W +: ADDR_W]
              < ADDR_W'(DEPTH_BYTES)) begin
            rd_v[i]        = 1'b1;
            rd_d[i*8 +: 8] = mem[io_rdAddr[i*ADDR_W +: IDX_W]];
          end else begin
            oor = 1'b1;
          end
        end
      end
    end
  end

`ifdef WBUF_RD_PIPE_EN
  logic [LANES-1:0]   s1_v;
  logic [LANES*8-1:0] s1_d;

  // A new load discards anything still in flight.
  always_ff @(posedge clock) begin
    if (reset || io_loadStart) begin
      s1_v       <= '0;
      s1_d       <= '0;
      io_rdValid <= '0;
      io_rdData  <= '0;
    end else begin
      s1_v       <= rd_v;
      s1_d       <= rd_d;
      io_rdValid <= s1_v;
      io_rdData  <= s1_d;
    end
  end
`else
  always_ff @(posedge clock) begin
    if (reset) begin
      io_rdValid <= '0;
      io_rdData  <= '0;
    end else begin
      io_rdValid <= rd_v;
      io_rdData  <= rd_d;
    end
  end
`endif

endmodule

// File: tb/tb_weight_buffer_responder.sv
// Randomized bench for weight_buffer_responder against a byte-array model.
module tb_weight_buffer_responder;

  localparam int LANES  = 16;
  localparam int ADDR_W = 17;
  localparam int DEPTH  = 9408;
  localparam int WORDS  = 1176;
`ifdef WBUF_RD_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic load_start = 1'b0;
  logic wr_en = 1'b0;
  logic [63:0] wr_data = '0;
  logic ready;
  logic [10:0] load_count;
  logic [LANES*ADDR_W-1:0] rd_addr = '0;
  logic [LANES-1:0] addr_valid = '0;
  logic [LANES*8-1:0] rd_data;
  logic [LANES-1:0] rd_valid;
  logic addr_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  weight_buffer_responder dut (
    .clock        (clock),
    .reset        (reset),
    .io_loadStart (load_start),
    .io_wrEn      (wr_en),
    .io_wrData    (wr_data),
    .io_ready     (ready),
    .io_loadCount (load_count),
    .io_rdAddr    (rd_addr),
    .io_addrValid (addr_valid),
    .io_rdData    (rd_data),
    .io_rdValid   (rd_valid),
    .io_addrErr   (addr_err)
  );

  // Behavioural model
  logic [7:0] m_mem [DEPTH];
  bit m_loading = 0;
  bit m_loaded = 0;
  bit m_err = 0;
  int m_cnt = 0;
  logic [LANES*8-1:0] m_d = '0;
  logic [LANES*8-1:0] p_d = '0;
  logic [LANES-1:0] m_v = '0;
  logic [LANES-1:0] p_v = '0;
  bit started = 0;

  initial for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;

  always @(posedge clock) begin : model
    logic [LANES*8-1:0] nd;
    logic [LANES-1:0] nv;
    bit hit_oor;
    int a;
    nd = '0;
    nv = '0;
    hit_oor = 0;
    for (int i = 0; i < LANES; i++) begin
      if (addr_valid[i] && m_loaded) begin
        a = int'(rd_addr[i*ADDR_W +: ADDR_W]);
        if (a < DEPTH) begin
          nv[i] = 1'b1;
          nd[i*8 +: 8] = m_mem[a];
        end else hit_oor = 1;
      end
    end
    if (reset) begin
      m_loading = 0; m_loaded = 0; m_err = 0; m_cnt = 0;
      m_v = '0; m_d = '0; p_v = '0; p_d = '0;
    end else if (load_start) begin
      m_loading = 1; m_loaded = 0; m_err = 0; m_cnt = 0;
      if (LAT == 2) begin
        m_v = '0; m_d = '0; p_v = '0; p_d = '0;
      end else begin
        m_v = nv; m_d = nd;
      end
    end else begin
      if (hit_oor) m_err = 1;
      if (m_loading && wr_en) begin
        for (int k = 0; k < 8; k++)
          m_mem[m_cnt*8 + k] = wr_data[8*k +: 8];
        m_cnt++;
        if (m_cnt == WORDS) begin
          m_loading = 0;
          m_loaded = 1;
        end
      end
      if (LAT == 2) begin
        m_v = p_v; m_d = p_d; p_v = nv; p_d = nd;
      end else begin
        m_v = nv; m_d = nd;
      end
    end
    started = 1;
  end

  task automatic chk(input string n, input logic [127:0] act,
                     input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (started) begin
      chk("ready", 128'(ready), 128'(m_loaded));
      chk("loadCount", 128'(load_count), 128'(m_cnt));
      chk("addrErr", 128'(addr_err), 128'(m_err));
      chk("rdValid", 128'(rd_valid), 128'(m_v));
      chk("rdData", 128'(rd_data), 128'(m_d));
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic idle();
    load_start = 1'b0;
    wr_en = 1'b0;
    addr_valid = '0;
  endtask

  task automatic set_lane(input int i, input int a);
    rd_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
  endtask

  task automatic rand_reads();
    for (int i = 0; i < LANES; i++) begin
      if ($urandom_range(15) == 0)
        set_lane(i, int'($urandom_range(DEPTH + 100, DEPTH)));
      else
        set_lane(i, int'($urandom_range(DEPTH - 1, 0)));
    end
    addr_valid = LANES'($urandom);
  endtask

  task automatic write_words(input int first, input int n, input bit rnd);
    int w;
    logic [7:0] b;
    w = first;
    while (w < first + n) begin
      rand_reads();
      if ($urandom_range(3) == 0) begin
        wr_en = 1'b0;
      end else begin
        wr_en = 1'b1;
        b = 8'(w);
        wr_data = rnd ? {$urandom, $urandom} : {8{b}};
        w++;
      end
      step();
    end
    wr_en = 1'b0;
    addr_valid = '0;
  endtask

  task automatic pulse_start(input bit with_wr);
    load_start = 1'b1;
    wr_en = with_wr;
    wr_data = {$urandom, $urandom};
    step();
    load_start = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin : stim
    logic [LANES*8-1:0] exp_d;
    idle();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    chk("rst_ready", 128'(ready), 128'd0);
    chk("rst_count", 128'(load_count), 128'd0);
    chk("rst_valid", 128'(rd_valid), 128'd0);
    chk("rst_data", 128'(rd_data), 128'd0);
    chk("rst_err", 128'(addr_err), 128'd0);

    // EMPTY: reads and writes are ignored
    rd_addr = '0;
    addr_valid = '1;
    for (int c = 0; c < 6; c++) begin
      wr_en = c[0];
      wr_data = {$urandom, $urandom};
      step();
    end
    idle();
    chk("empty_valid", 128'(rd_valid), 128'd0);
    chk("empty_count", 128'(load_count), 128'd0);

    pulse_start(1'b1);
    write_words(0, WORDS, 1'b0);
    chk("load_ready", 128'(ready), 128'd1);
    chk("load_count", 128'(load_count), 128'd1176);

    for (int i = 0; i < LANES; i++) begin
      set_lane(i, 8*i + 3);
      exp_d[i*8 +: 8] = 8'(i);
    end
    addr_valid = '1;
    step();
    addr_valid = '0;
    repeat (LAT - 1) step();
    chk("lane_valid", 128'(rd_valid), 128'hFFFF);
    chk("lane_data", 128'(rd_data), 128'(exp_d));

    for (int i = 0; i < LANES; i++) begin
      set_lane(i, DEPTH - 1);
      exp_d[i*8 +: 8] = (i == 4 || i == 9) ? 8'h00 : 8'h97;
    end
    addr_valid = 16'hFDEF;
    step();
    addr_valid = '0;
    repeat (LAT - 1) step();
    chk("top_valid", 128'(rd_valid), 128'hFDEF);
    chk("top_data", 128'(rd_data), 128'(exp_d));

    set_lane(2, DEPTH);
    addr_valid = 16'h0004;
    step();
    addr_valid = '0;
    repeat (LAT - 1) step();
    chk("oor_valid", 128'(rd_valid), 128'd0);
    chk("oor_data", 128'(rd_data), 128'd0);
    repeat (3) step();
    chk("oor_err", 128'(addr_err), 128'd1);

    for (int c = 0; c < 400; c++) begin
      rand_reads();
      wr_en = 1'(c % 3 == 0);
      step();
    end
    idle();
    chk("sticky_err", 128'(addr_err), 128'd1);

    pulse_start(1'b0);
    chk("start_err", 128'(addr_err), 128'd0);
    chk("start_ready", 128'(ready), 128'd0);
    write_words(0, 500, 1'b1);
    pulse_start(1'b1);
    chk("restart_count", 128'(load_count), 128'd0);
    write_words(0, 600, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_count", 128'(load_count), 128'd0);
    chk("midrst_ready", 128'(ready), 128'd0);
    wr_en = 1'b1;
    repeat (3) step();
    wr_en = 1'b0;

    pulse_start(1'b0);
    write_words(0, WORDS, 1'b1);
    for (int base = 0; base < DEPTH; base += LANES) begin
      for (int i = 0; i < LANES; i++) set_lane(i, base + i);
      addr_valid = '1;
      step();
    end
    for (int c = 0; c < 300; c++) begin
      rand_reads();
      step();
    end
    rand_reads();
    pulse_start(1'b0);
    idle();
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
